// File: rtl/imem_boot_loader.sv
// imem_boot_loader: instruction memory with a bench-side program-load port.
// The core is held stalled while the bench writes words. After tb_done, the
// block drains for FLUSH_CYCLES and then releases the core, which fetches
// from the same memory.
// Ports:
//   clk, reset             - clock; asynchronous active-high reset
//   tb_valid/addr/inst     - bench word-write strobe, byte address, data
//   tb_done                - bench pulse marking program load complete
//   fetch_en/fetch_addr    - core fetch request and PC (byte address)
//   fetch_inst             - registered fetched instruction
//   core_run               - core may execute
//   load_count             - number of distinct words written
//   load_err               - sticky flag for rejected load writes
module imem_boot_loader #(
    parameter int unsigned DEPTH        = 256,
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter logic [31:0] NOP_INST     = 32'h0000_0013
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       tb_valid,
    input  logic [31:0]                tb_addr,
    input  logic [31:0]                tb_inst,
    input  logic                       tb_done,
    input  logic                       fetch_en,
    input  logic [31:0]                fetch_addr,
    output logic [31:0]                fetch_inst,
    output logic                       core_run,
    output logic [$clog2(DEPTH):0]     load_count,
    output logic                       load_err
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned FW = $clog2(FLUSH_CYCLES + 1);
    localparam logic [31:0] ADDR_LIMIT = 32'(DEPTH * 4);

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        FLUSH = 2'd1,
        RUN   = 2'd2
    } state_t;

    state_t            state;
    logic [FW-1:0]     flush_cnt;
    logic [DEPTH-1:0]  valid;
    logic [31:0]       mem [DEPTH];

    // Address decode for the load and fetch ports.
    logic [AW-1:0] wr_idx_c;
    logic [AW-1:0] rd_idx_c;
    logic          wr_ok_c;
    logic          rd_ok_c;
    logic          wr_en_c;

    always_comb begin
        wr_idx_c = tb_addr[AW+1:2];
        rd_idx_c = fetch_addr[AW+1:2];
        wr_ok_c  = (tb_addr[1:0] == 2'b00) && (tb_addr < ADDR_LIMIT);
        rd_ok_c  = (fetch_addr[1:0] == 2'b00) && (fetch_addr < ADDR_LIMIT)
                   && valid[rd_idx_c];
        wr_en_c  = (state == LOAD) && tb_valid && wr_ok_c;
    end

    // Memory array is deliberately not reset; the valid bits mask stale data.
    always_ff @(posedge clk) begin
        if (wr_en_c) begin
            mem[wr_idx_c] <= tb_inst;
        end
    end

    // Control FSM with registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= LOAD;
            flush_cnt  <= '0;
            valid      <= '0;
            core_run   <= 1'b0;
            load_count <= '0;
            load_err   <= 1'b0;
            fetch_inst <= NOP_INST;
        end else begin
            case (state)
                LOAD: begin
                    fetch_inst <= NOP_INST;
                    if (tb_valid) begin
                        if (wr_ok_c) begin
                            valid[wr_idx_c] <= 1'b1;
                            if (!valid[wr_idx_c]) begin
                                load_count <= load_count + CW'(1);
                            end
                        end else begin
                            load_err <= 1'b1;
                        end
                    end
                    if (tb_done) begin
                        state     <= FLUSH;
                        flush_cnt <= '0;
                    end
                end
                FLUSH: begin
                    fetch_inst <= NOP_INST;
                    // Release lands FLUSH_CYCLES+1 edges after tb_done was sampled.
                    if (flush_cnt == FW'(FLUSH_CYCLES)) begin
                        state    <= RUN;
                        core_run <= 1'b1;
                    end else begin
                        flush_cnt <= flush_cnt + FW'(1);
                    end
                end
                RUN: begin
                    core_run <= 1'b1;
                    if (fetch_en) begin
                        fetch_inst <= rd_ok_c ? mem[rd_idx_c] : NOP_INST;
                    end
                end
                default: begin
                    state    <= LOAD;
                    core_run <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_boot_loader.sv
// tb_imem_boot_loader: randomized self-checking bench for imem_boot_loader.
// A behavioural model (word array + valid flags + counters) predicts every
// output; loads, flush timing, fetches, holds and mid-run reset are checked.
module tb_imem_boot_loader;

    localparam int unsigned DEPTH        = 256;
    localparam int unsigned FLUSH_CYCLES = 2;
    localparam logic [31:0] NOP          = 32'h0000_0013;
    localparam int unsigned CW           = $clog2(DEPTH) + 1;

    logic          clk;
    logic          reset;
    logic          tb_valid;
    logic [31:0]   tb_addr;
    logic [31:0]   tb_inst;
    logic          tb_done;
    logic          fetch_en;
    logic [31:0]   fetch_addr;
    logic [31:0]   fetch_inst;
    logic          core_run;
    logic [CW-1:0] load_count;
    logic          load_err;

    imem_boot_loader #(
        .DEPTH        (DEPTH),
        .FLUSH_CYCLES (FLUSH_CYCLES),
        .NOP_INST     (NOP)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .tb_valid   (tb_valid),
        .tb_addr    (tb_addr),
        .tb_inst    (tb_inst),
        .tb_done    (tb_done),
        .fetch_en   (fetch_en),
        .fetch_addr (fetch_addr),
        .fetch_inst (fetch_inst),
        .core_run   (core_run),
        .load_count (load_count),
        .load_err   (load_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state.
    logic [31:0] ref_mem [DEPTH];
    bit          ref_valid [DEPTH];
    int          ref_count;
    bit          ref_err;
    logic [31:0] last_fetch;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic bit addr_ok(input logic [31:0] a);
        return (a % 4 == 0) && (a < DEPTH * 4);
    endfunction

    function automatic logic [31:0] ref_fetch(input logic [31:0] a);
        if (!addr_ok(a)) return NOP;
        if (!ref_valid[int'(a / 4)]) return NOP;
        return ref_mem[int'(a / 4)];
    endfunction

    task automatic ref_write(input logic [31:0] a, input logic [31:0] d);
        if (addr_ok(a)) begin
            if (!ref_valid[int'(a / 4)]) ref_count++;
            ref_valid[int'(a / 4)] = 1'b1;
            ref_mem[int'(a / 4)]   = d;
        end else begin
            ref_err = 1'b1;
        end
    endtask

    task automatic ref_reset();
        for (int i = 0; i < DEPTH; i++) ref_valid[i] = 1'b0;
        ref_count  = 0;
        ref_err    = 1'b0;
        last_fetch = NOP;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_status(input string tag);
        check({tag, "_count"}, 32'(load_count), 32'(ref_count));
        check({tag, "_err"}, 32'(load_err), 32'(ref_err));
    endtask

    // One load-phase write; fetch_en is randomized to show it is ignored.
    task automatic load(input logic [31:0] a, input logic [31:0] d, input bit done);
        tb_valid   = 1'b1;
        tb_addr    = a;
        tb_inst    = d;
        tb_done    = done;
        fetch_en   = 1'($urandom);
        fetch_addr = 32'h0;
        step();
        tb_valid = 1'b0;
        tb_done  = 1'b0;
        fetch_en = 1'b0;
        ref_write(a, d);
        check_status("load");
        check("load_fetch_nop", fetch_inst, NOP);
        check("load_run", 32'(core_run), 32'h0);
    endtask

    // Edges after tb_done: core stays stalled, junk writes/done pulses ignored.
    task automatic release_core();
        for (int i = 1; i <= FLUSH_CYCLES + 1; i++) begin
            tb_valid   = 1'b1;
            tb_addr    = 32'h14;
            tb_inst    = 32'hBAD0_BAD0;
            tb_done    = 1'($urandom);
            fetch_en   = 1'b1;
            fetch_addr = 32'h0;
            step();
            check("flush_run", 32'(core_run), (i == FLUSH_CYCLES + 1) ? 32'h1 : 32'h0);
            check("flush_fetch_nop", fetch_inst, NOP);
            check_status("flush");
        end
        tb_valid   = 1'b0;
        tb_done    = 1'b0;
        fetch_en   = 1'b0;
        last_fetch = NOP;
    endtask

    // Write attempts while running must change nothing.
    task automatic run_ignored(input int n);
        for (int i = 0; i < n; i++) begin
            tb_valid = 1'b1;
            case ($urandom_range(0, 2))
                0:       tb_addr = 32'h20;
                1:       tb_addr = 32'h2;
                default: tb_addr = 32'h400;
            endcase
            tb_inst = $urandom;
            tb_done = 1'b1;
            step();
            check_status("run_ignore");
            check("run_ignore_run", 32'(core_run), 32'h1);
        end
        tb_valid = 1'b0;
        tb_done  = 1'b0;
    endtask

    task automatic fetch(input logic [31:0] a);
        fetch_en   = 1'b1;
        fetch_addr = a;
        step();
        fetch_en   = 1'b0;
        last_fetch = ref_fetch(a);
        check($sformatf("fetch_%0h", a), fetch_inst, last_fetch);
    endtask

    task automatic hold_check();
        fetch_en   = 1'b0;
        fetch_addr = 32'h0;
        step();
        check("fetch_hold", fetch_inst, last_fetch);
    endtask

    initial begin
        logic [31:0] a;

        reset      = 1'b1;
        tb_valid   = 1'b0;
        tb_addr    = '0;
        tb_inst    = '0;
        tb_done    = 1'b0;
        fetch_en   = 1'b0;
        fetch_addr = '0;
        ref_reset();
        #1;
        check("rst_fetch", fetch_inst, NOP);
        check("rst_run", 32'(core_run), 32'h0);
        check_status("rst");
        #11 reset = 1'b0;
        #1;

        // Directed program and boundary writes.
        load(32'h0, 32'h0050_0093, 1'b0);
        load(32'h4, 32'h00A0_0113, 1'b0);
        load(32'h8, 32'h0020_81B3, 1'b0);
        load(32'h10, 32'h1111_1111, 1'b0);
        load(32'h10, 32'h2222_2222, 1'b0);
        load(32'h2, 32'h3333_3333, 1'b0);
        load(32'h400, 32'h4444_4444, 1'b0);

        // Random loads above the directed region, with occasional bad addresses.
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 7) == 0)
                a = ($urandom_range(0, 1) == 1) ? 32'(DEPTH * 4 + 4 * $urandom_range(0, 15))
                                                : 32'(4 * $urandom_range(16, DEPTH - 1) + 1);
            else
                a = 32'(4 * $urandom_range(16, DEPTH - 1));
            load(a, $urandom, 1'b0);
        end

        // Final write coincides with tb_done.
        load(32'hC, 32'hDEAD_BEEF, 1'b1);
        release_core();
        run_ignored(6);

        fetch(32'h0);
        fetch(32'h4);
        fetch(32'h8);
        fetch(32'hC);
        hold_check();
        fetch(32'h10);
        fetch(32'h14);
        fetch(32'h20);
        fetch(32'h0);
        fetch(32'h400);
        fetch(32'h2);
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 3))
                0:       a = 32'(4 * $urandom_range(0, DEPTH - 1));
                1:       a = 32'(4 * $urandom_range(0, DEPTH - 1) + $urandom_range(1, 3));
                2:       a = 32'(DEPTH * 4 + 4 * $urandom_range(0, 63));
                default: a = 32'(4 * $urandom_range(16, DEPTH - 1));
            endcase
            fetch(a);
            if ($urandom_range(0, 3) == 0) hold_check();
        end

        // Asynchronous reset in the middle of RUN.
        fetch(32'h4);
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        ref_reset();
        check("mid_rst_run", 32'(core_run), 32'h0);
        check("mid_rst_fetch", fetch_inst, NOP);
        check_status("mid_rst");
        #8 reset = 1'b0;
        @(posedge clk);
        #1;

        // Reload only word 0; the rest of the old program must be gone.
        load(32'h0, 32'hCAFE_0001, 1'b1);
        release_core();
        run_ignored(4);
        fetch(32'h4);
        fetch(32'h8);
        fetch(32'h0);
        hold_check();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
